// File: rtl/ram_dumper_if.sv
// RAM read port and UART TX handshake shared between ram_dumper and its neighbours.
// master = dumper side (drives address/byte/transmit), slave = RAM + UART side.
// Purely structural: no clocking or state lives in here.
interface ram_dumper_if;
  logic [15:0] ram_addr;
  logic [7:0]  ram_do;
  logic [7:0]  tx_data;
  logic        transmit;
  logic        tx_done;

  modport master (
    output ram_addr,
    output tx_data,
    output transmit,
    input  ram_do,
    input  tx_done
  );

  modport slave (
    input  ram_addr,
    input  tx_data,
    input  transmit,
    output ram_do,
    output tx_done
  );
endinterface

// File: rtl/ram_dumper.sv
// Streams a RAM region out of the UART on a trigger edge while holding the CPU in reset.
// Latency: first transmit 2 cycles after the sampled edge; 3 cycles + UART byte time per byte.
// Backpressure: one byte in flight, next byte only after tx_done. Option: DUMP_CHECKSUM_EN.
module ram_dumper #(
  parameter int MAX_LEN = 65535
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          trigger,
  input  logic [15:0]   start_addr,
  input  logic [15:0]   length,
  output logic          dumping,
  output logic          cpu_rst,
  output logic          done,
  ram_dumper_if.master  bus
);

`ifdef DUMP_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, READ, LOAD, WAIT_TX, CSUM, FINISH} state_t;
`else
  typedef enum logic [2:0] {IDLE, READ, LOAD, WAIT_TX, FINISH} state_t;
`endif

  localparam logic [15:0] MAX_LEN_W = 16'(MAX_LEN);

  state_t      state;
  state_t      state_nxt;
  logic        trigger_q;
  logic        start;
  logic [15:0] len_clamped;
  logic [15:0] addr;
  logic [15:0] remaining;
  logic [7:0]  tx_data_q;
  logic        dumping_nxt;

`ifdef DUMP_CHECKSUM_EN
  logic [7:0]  sum;
  logic        csum_sent;
  logic [7:0]  csum_byte;

  // Two's complement of the running sum makes the whole stream sum to zero.
  assign csum_byte = ~sum + 8'd1;
`endif

  assign start       = (state == IDLE) && trigger && !trigger_q;
  assign len_clamped = (length > MAX_LEN_W) ? MAX_LEN_W : length;

  // addr doubles as the RAM address; it only moves on start and on tx_done,
  // so it naturally holds its last value while idle.
  assign bus.ram_addr = addr;
  assign bus.transmit = (state == LOAD)
`ifdef DUMP_CHECKSUM_EN
                        || (state == CSUM)
`endif
                        ;
  assign done    = (state == FINISH);
  assign cpu_rst = dumping;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode; dumping falls in the same cycle done pulses.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (len_clamped == 16'd0) begin
`ifdef DUMP_CHECKSUM_EN
            state_nxt = CSUM;
`else
            state_nxt = FINISH;
`endif
          end else begin
            state_nxt = READ;
          end
        end
      end
      READ:    state_nxt = LOAD;
      LOAD:    state_nxt = WAIT_TX;
      WAIT_TX: begin
        if (bus.tx_done) begin
`ifdef DUMP_CHECKSUM_EN
          if (csum_sent)                   state_nxt = FINISH;
          else if (remaining != 16'd1)     state_nxt = READ;
          else                             state_nxt = CSUM;
`else
          if (remaining != 16'd1)          state_nxt = READ;
          else                             state_nxt = FINISH;
`endif
        end
      end
`ifdef DUMP_CHECKSUM_EN
      CSUM:    state_nxt = WAIT_TX;
`endif
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    dumping_nxt = (state_nxt != IDLE) && (state_nxt != FINISH);
  end

  // Datapath: address/count bookkeeping, byte capture, checksum accumulation.
  always_ff @(posedge clk) begin
    if (rst) begin
      trigger_q <= 1'b0;
      addr      <= 16'd0;
      remaining <= 16'd0;
      tx_data_q <= 8'd0;
      dumping   <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
      sum       <= 8'd0;
      csum_sent <= 1'b0;
`endif
    end else begin
      trigger_q <= trigger;
      dumping   <= dumping_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            addr      <= start_addr;
            remaining <= len_clamped;
`ifdef DUMP_CHECKSUM_EN
            sum       <= 8'd0;
            csum_sent <= 1'b0;
`endif
          end
        end
        LOAD: begin
          tx_data_q <= bus.ram_do;
`ifdef DUMP_CHECKSUM_EN
          sum       <= sum + bus.ram_do;
`endif
        end
        WAIT_TX: begin
`ifdef DUMP_CHECKSUM_EN
          if (bus.tx_done && !csum_sent) begin
`else
          if (bus.tx_done) begin
`endif
            addr      <= addr + 16'd1;
            remaining <= remaining - 16'd1;
          end
        end
`ifdef DUMP_CHECKSUM_EN
        CSUM: begin
          tx_data_q <= csum_byte;
          csum_sent <= 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

  // The byte must be on tx_data in the same cycle transmit pulses, so the
  // freshly read RAM byte (or checksum) bypasses the holding register.
  always_comb begin
    bus.tx_data = tx_data_q;
    if (state == LOAD) bus.tx_data = bus.ram_do;
`ifdef DUMP_CHECKSUM_EN
    if (state == CSUM) bus.tx_data = csum_byte;
`endif
  end

endmodule

// File: tb/tb_ram_dumper.sv
// Directed bench for ram_dumper: RAM model with one-cycle read latency and a UART
// model that answers each transmit with tx_done 10 cycles later.
// Expected byte streams are hand computed; DUMP_CHECKSUM_EN adds the checksum byte.
module tb_ram_dumper;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        trigger = 1'b0;
  logic [15:0] start_addr = 16'd0;
  logic [15:0] length = 16'd0;
  logic        dumping;
  logic        cpu_rst;
  logic        done;

  ram_dumper_if bus ();

  ram_dumper #(.MAX_LEN(65535)) dut (
    .clk        (clk),
    .rst        (rst),
    .trigger    (trigger),
    .start_addr (start_addr),
    .length     (length),
    .dumping    (dumping),
    .cpu_rst    (cpu_rst),
    .done       (done),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  logic [7:0]  mem [0:65535];
  logic [7:0]  ram_q = 8'd0;
  logic        uart_done = 1'b0;
  logic        inj_done = 1'b0;
  int          uart_cnt = 0;
  int          cyc = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          last_txdone_cyc = 0;
  logic        dumping_at_done = 1'b0;
  logic [7:0]  tx_log [$];
  logic [15:0] addr_log [$];
  int          vec = 0;
  int          errs = 0;

  assign bus.ram_do  = ram_q;
  assign bus.tx_done = uart_done | inj_done;

  // RAM: data one cycle after address.
  always @(posedge clk) ram_q <= mem[bus.ram_addr];

  // UART model plus transmit/done monitor.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    uart_done <= 1'b0;
    if (rst) begin
      uart_cnt <= 0;
    end else begin
      if (uart_cnt > 0) begin
        uart_cnt <= uart_cnt - 1;
        if (uart_cnt == 1) uart_done <= 1'b1;
      end
      if (bus.transmit) begin
        uart_cnt <= 10;
        tx_log.push_back(bus.tx_data);
        addr_log.push_back(bus.ram_addr);
      end
    end
    if (uart_done) last_txdone_cyc <= cyc;
    if (done) begin
      done_cnt        <= done_cnt + 1;
      done_cyc        <= cyc;
      dumping_at_done <= dumping;
    end
  end

  task automatic start_dump(input logic [15:0] sa, input logic [15:0] len);
    @(posedge clk); #1;
    start_addr = sa;
    length     = len;
    trigger    = 1'b1;
    @(posedge clk); #1;
    trigger    = 1'b0;
  endtask

  task automatic wait_done(input int target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done_cnt >= target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_tx(input int target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (tx_log.size() >= target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    vec++; if (dumping !== 1'b0)        begin errs++; $display("FAIL reset_dumping got %h exp 0", dumping); end
    vec++; if (cpu_rst !== 1'b0)        begin errs++; $display("FAIL reset_cpu_rst got %h exp 0", cpu_rst); end
    vec++; if (bus.ram_addr !== 16'h0)  begin errs++; $display("FAIL reset_ram_addr got %h exp 0000", bus.ram_addr); end
    vec++; if (bus.tx_data !== 8'h0)    begin errs++; $display("FAIL reset_tx_data got %h exp 00", bus.tx_data); end
    vec++; if (bus.transmit !== 1'b0)   begin errs++; $display("FAIL reset_transmit got %h exp 0", bus.transmit); end
    vec++; if (done !== 1'b0)           begin errs++; $display("FAIL reset_done got %h exp 0", done); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [7:0] exp [$];
    int base_tx, base_done;
    bit ok;
    exp = '{8'h11, 8'h22, 8'h33, 8'h44};
`ifdef DUMP_CHECKSUM_EN
    exp.push_back(8'h56);
`endif
    base_tx = tx_log.size();
    base_done = done_cnt;
    @(posedge clk); #1;
    start_addr = 16'h0100; length = 16'd4; trigger = 1'b1;
    @(posedge clk); #1;
    trigger = 1'b0;
    @(negedge clk);
    vec++; if (dumping !== 1'b1)          begin errs++; $display("FAIL basic_dumping_n1 got %h exp 1", dumping); end
    vec++; if (cpu_rst !== 1'b1)          begin errs++; $display("FAIL basic_cpu_rst_n1 got %h exp 1", cpu_rst); end
    vec++; if (bus.ram_addr !== 16'h0100) begin errs++; $display("FAIL basic_ram_addr_n1 got %h exp 0100", bus.ram_addr); end
    vec++; if (bus.transmit !== 1'b0)     begin errs++; $display("FAIL basic_transmit_n1 got %h exp 0", bus.transmit); end
    @(negedge clk);
    vec++; if (bus.transmit !== 1'b1)     begin errs++; $display("FAIL basic_transmit_n2 got %h exp 1", bus.transmit); end
    vec++; if (bus.tx_data !== 8'h11)     begin errs++; $display("FAIL basic_tx_data_n2 got %h exp 11", bus.tx_data); end
    wait_done(base_done + 1, ok);
    vec++; if (!ok) begin errs++; $display("FAIL basic_timeout got no done exp done"); end
    repeat (3) @(negedge clk);
    vec++; if (tx_log.size() !== base_tx + exp.size())
      begin errs++; $display("FAIL basic_count got %0d exp %0d", tx_log.size() - base_tx, exp.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      logic [7:0] got;
      got = (base_tx + i < tx_log.size()) ? tx_log[base_tx + i] : 8'hxx;
      vec++; if (got !== exp[i]) begin errs++; $display("FAIL basic_byte%0d got %h exp %h", i, got, exp[i]); end
    end
    vec++; if (done_cnt !== base_done + 1) begin errs++; $display("FAIL basic_done_cnt got %0d exp %0d", done_cnt - base_done, 1); end
    vec++; if (done_cyc !== last_txdone_cyc + 1)
      begin errs++; $display("FAIL basic_done_timing got %0d exp %0d", done_cyc, last_txdone_cyc + 1); end
    vec++; if (dumping_at_done !== 1'b0) begin errs++; $display("FAIL basic_dumping_at_done got %h exp 0", dumping_at_done); end
    vec++; if (dumping !== 1'b0) begin errs++; $display("FAIL basic_dumping_after got %h exp 0", dumping); end
  endtask

  task automatic test_wrap();
    logic [7:0]  exp [$];
    logic [15:0] exp_a [3];
    int base_tx, base_done;
    bit ok;
    exp = '{8'hA0, 8'hA1, 8'hA2};
    exp_a = '{16'hFFFE, 16'hFFFF, 16'h0000};
`ifdef DUMP_CHECKSUM_EN
    exp.push_back(8'h1D);
`endif
    base_tx = tx_log.size();
    base_done = done_cnt;
    start_dump(16'hFFFE, 16'd3);
    wait_done(base_done + 1, ok);
    vec++; if (!ok) begin errs++; $display("FAIL wrap_timeout got no done exp done"); end
    repeat (3) @(negedge clk);
    vec++; if (tx_log.size() !== base_tx + exp.size())
      begin errs++; $display("FAIL wrap_count got %0d exp %0d", tx_log.size() - base_tx, exp.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      logic [7:0] got;
      got = (base_tx + i < tx_log.size()) ? tx_log[base_tx + i] : 8'hxx;
      vec++; if (got !== exp[i]) begin errs++; $display("FAIL wrap_byte%0d got %h exp %h", i, got, exp[i]); end
    end
    for (int i = 0; i < 3; i++) begin
      logic [15:0] got_a;
      got_a = (base_tx + i < addr_log.size()) ? addr_log[base_tx + i] : 16'hxxxx;
      vec++; if (got_a !== exp_a[i]) begin errs++; $display("FAIL wrap_addr%0d got %h exp %h", i, got_a, exp_a[i]); end
    end
    vec++; if (done_cnt !== base_done + 1) begin errs++; $display("FAIL wrap_done_cnt got %0d exp 1", done_cnt - base_done); end
  endtask

  task automatic test_zero();
    int base_tx, base_done, exp_n;
    bit ok;
`ifdef DUMP_CHECKSUM_EN
    exp_n = 1;
`else
    exp_n = 0;
`endif
    base_tx = tx_log.size();
    base_done = done_cnt;
    start_dump(16'h0100, 16'd0);
    wait_done(base_done + 1, ok);
    vec++; if (!ok) begin errs++; $display("FAIL zero_timeout got no done exp done"); end
    repeat (5) @(negedge clk);
    vec++; if (tx_log.size() !== base_tx + exp_n)
      begin errs++; $display("FAIL zero_count got %0d exp %0d", tx_log.size() - base_tx, exp_n); end
    if (exp_n == 1) begin
      logic [7:0] got;
      got = (base_tx < tx_log.size()) ? tx_log[base_tx] : 8'hxx;
      vec++; if (got !== 8'h00) begin errs++; $display("FAIL zero_csum got %h exp 00", got); end
    end
    vec++; if (done_cnt !== base_done + 1) begin errs++; $display("FAIL zero_done_cnt got %0d exp 1", done_cnt - base_done); end
    vec++; if (dumping !== 1'b0) begin errs++; $display("FAIL zero_dumping got %h exp 0", dumping); end
  endtask

  task automatic test_interference();
    logic [7:0] exp [$];
    int base_tx, base_done;
    bit ok;
    exp = '{8'h11, 8'h22, 8'h33, 8'h44};
`ifdef DUMP_CHECKSUM_EN
    exp.push_back(8'h56);
`endif
    base_tx = tx_log.size();
    base_done = done_cnt;
    start_dump(16'h0100, 16'd4);
    wait_tx(base_tx + 2, ok);
    vec++; if (!ok) begin errs++; $display("FAIL intf_tx_timeout got no byte2 exp byte2"); end
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (uart_done) begin ok = 1'b1; break; end
    end
    vec++; if (!ok) begin errs++; $display("FAIL intf_txdone_timeout got none exp tx_done"); end
    @(posedge clk); #1;
    inj_done = 1'b1;
    trigger  = 1'b1;
    @(negedge clk);
    vec++; if (bus.ram_addr !== 16'h0102) begin errs++; $display("FAIL intf_read_addr got %h exp 0102", bus.ram_addr); end
    @(posedge clk); #1;
    inj_done = 1'b0;
    trigger  = 1'b0;
    wait_done(base_done + 1, ok);
    vec++; if (!ok) begin errs++; $display("FAIL intf_timeout got no done exp done"); end
    repeat (20) @(negedge clk);
    vec++; if (tx_log.size() !== base_tx + exp.size())
      begin errs++; $display("FAIL intf_count got %0d exp %0d", tx_log.size() - base_tx, exp.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      logic [7:0] got;
      got = (base_tx + i < tx_log.size()) ? tx_log[base_tx + i] : 8'hxx;
      vec++; if (got !== exp[i]) begin errs++; $display("FAIL intf_byte%0d got %h exp %h", i, got, exp[i]); end
    end
    vec++; if (done_cnt !== base_done + 1) begin errs++; $display("FAIL intf_done_cnt got %0d exp 1", done_cnt - base_done); end
    vec++; if (dumping !== 1'b0) begin errs++; $display("FAIL intf_restart got dumping %h exp 0", dumping); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp [$];
    int base_tx, base_done;
    bit ok;
    base_tx = tx_log.size();
    base_done = done_cnt;
    start_dump(16'h0100, 16'd4);
    wait_tx(base_tx + 2, ok);
    vec++; if (!ok) begin errs++; $display("FAIL rstmid_tx_timeout got no byte2 exp byte2"); end
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    vec++; if (dumping !== 1'b0)       begin errs++; $display("FAIL rstmid_dumping got %h exp 0", dumping); end
    vec++; if (cpu_rst !== 1'b0)       begin errs++; $display("FAIL rstmid_cpu_rst got %h exp 0", cpu_rst); end
    vec++; if (bus.ram_addr !== 16'h0) begin errs++; $display("FAIL rstmid_ram_addr got %h exp 0000", bus.ram_addr); end
    vec++; if (bus.tx_data !== 8'h0)   begin errs++; $display("FAIL rstmid_tx_data got %h exp 00", bus.tx_data); end
    vec++; if (bus.transmit !== 1'b0)  begin errs++; $display("FAIL rstmid_transmit got %h exp 0", bus.transmit); end
    repeat (20) @(negedge clk);
    vec++; if (done_cnt !== base_done) begin errs++; $display("FAIL rstmid_no_done got %0d exp 0", done_cnt - base_done); end
    vec++; if (tx_log.size() !== base_tx + 2)
      begin errs++; $display("FAIL rstmid_bytes got %0d exp 2", tx_log.size() - base_tx); end
    exp = '{8'hA0, 8'hA1, 8'hA2};
`ifdef DUMP_CHECKSUM_EN
    exp.push_back(8'h1D);
`endif
    base_tx = tx_log.size();
    start_dump(16'hFFFE, 16'd3);
    wait_done(base_done + 1, ok);
    vec++; if (!ok) begin errs++; $display("FAIL rstmid_redump_timeout got no done exp done"); end
    repeat (3) @(negedge clk);
    vec++; if (tx_log.size() !== base_tx + exp.size())
      begin errs++; $display("FAIL rstmid_redump_count got %0d exp %0d", tx_log.size() - base_tx, exp.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      logic [7:0] got;
      got = (base_tx + i < tx_log.size()) ? tx_log[base_tx + i] : 8'hxx;
      vec++; if (got !== exp[i]) begin errs++; $display("FAIL rstmid_redump_byte%0d got %h exp %h", i, got, exp[i]); end
    end
  endtask

  task automatic test_held();
    int base_tx, base_done, n;
    bit ok;
`ifdef DUMP_CHECKSUM_EN
    n = 3;
`else
    n = 2;
`endif
    base_tx = tx_log.size();
    base_done = done_cnt;
    @(posedge clk); #1;
    start_addr = 16'h0100; length = 16'd2; trigger = 1'b1;
    wait_done(base_done + 1, ok);
    vec++; if (!ok) begin errs++; $display("FAIL held_timeout got no done exp done"); end
    repeat (30) @(negedge clk);
    vec++; if (done_cnt !== base_done + 1) begin errs++; $display("FAIL held_single_done got %0d exp 1", done_cnt - base_done); end
    vec++; if (tx_log.size() !== base_tx + n)
      begin errs++; $display("FAIL held_count got %0d exp %0d", tx_log.size() - base_tx, n); end
    vec++; if (dumping !== 1'b0) begin errs++; $display("FAIL held_dumping got %h exp 0", dumping); end
    @(posedge clk); #1;
    trigger = 1'b0;
    @(posedge clk); #1;
    trigger = 1'b1;
    wait_done(base_done + 2, ok);
    vec++; if (!ok) begin errs++; $display("FAIL held_retrigger_timeout got no done exp done"); end
    @(posedge clk); #1;
    trigger = 1'b0;
    repeat (5) @(negedge clk);
    vec++; if (tx_log.size() !== base_tx + 2 * n)
      begin errs++; $display("FAIL held_retrigger_count got %0d exp %0d", tx_log.size() - base_tx, 2 * n); end
    begin
      logic [7:0] got;
      got = (base_tx + n + 1 < tx_log.size()) ? tx_log[base_tx + n + 1] : 8'hxx;
      vec++; if (got !== 8'h22) begin errs++; $display("FAIL held_retrigger_byte1 got %h exp 22", got); end
    end
  endtask

  initial begin
    mem[16'h0100] = 8'h11;
    mem[16'h0101] = 8'h22;
    mem[16'h0102] = 8'h33;
    mem[16'h0103] = 8'h44;
    mem[16'hFFFE] = 8'hA0;
    mem[16'hFFFF] = 8'hA1;
    mem[16'h0000] = 8'hA2;
    test_reset();
    test_basic();
    test_wrap();
    test_zero();
    test_interference();
    test_reset_mid();
    test_held();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
